sram_req_arbiter: RTL and testbench
===================================

SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

Interface
REQ-001 Parameters SHALL be:
- NUM_CH, 2, number of SRAM-like requester channels (2..8).
- DEPTH, 4, maximum outstanding requests (power of two, 2..16).
- ID_W, 3, width of the channel id.

REQ-002 Ports SHALL be:
- clk  in  1  single clock, rising edge
- resetn  in  1  asynchronous active-low reset
- ch_req  in  NUM_CH  per-channel request valid
- ch_wr  in  NUM_CH  per-channel write flag (1=store)
- ch_size  in  2*NUM_CH  per-channel size (0 byte, 1 half, 2 word)
- ch_wstrb  in  4*NUM_CH  per-channel byte strobes
- ch_addr  in  32*NUM_CH  per-channel address
- ch_wdata  in  32*NUM_CH  per-channel write data
- ch_addr_ok  out  NUM_CH  request accepted this cycle (one-hot or zero)
- ch_data_ok  out  NUM_CH  response delivered this cycle (one-hot or zero)
- ch_rdata  out  32  read data, broadcast to all channels
- mem_req_valid  out  1  downstream request valid
- mem_req_ready  in  1  downstream accepts request
- mem_req_wr, mem_req_size, mem_req_wstrb, mem_req_addr, mem_req_wdata  out  1/2/4/32/32  fields of the granted channel
- mem_req_id  out  ID_W  granted channel index
- mem_rsp_valid  in  1  downstream response valid; always accepted, no ready
- mem_rsp_id  in  ID_W  id of the response
- mem_rsp_rdata  in  32  response data (don't-care for writes)
- outstanding  out  $clog2(DEPTH)+1  requests in flight
- err  out  1  sticky protocol-error flag

Function
REQ-003 Eligible set SHALL be ch_req, masked to zero when the owner FIFO is full.
REQ-004 Grant SHALL be round-robin: search starts at rr_ptr and wraps modulo NUM_CH; the first eligible channel wins.
REQ-005 mem_req_valid SHALL equal |eligible, combinationally; all mem_req fields SHALL come from the granted channel.
REQ-006 On mem_req_valid && mem_req_ready, ch_addr_ok[grant] SHALL be 1 in the same cycle (zero-cycle accept).
REQ-007 On that handshake, grant SHALL be pushed into the owner FIFO and rr_ptr SHALL become (grant+1) mod NUM_CH at the next edge; otherwise rr_ptr SHALL hold.
REQ-008 The grant SHALL stay stable while mem_req_valid is high and mem_req_ready is low, unless the granted channel drops ch_req.
REQ-009 Responses are in order. When mem_rsp_valid=1 and the FIFO is non-empty:
- the head owner SHALL be popped;
- ch_data_ok[head] SHALL be 1 in the same cycle;
- ch_rdata SHALL equal mem_rsp_rdata.
REQ-010 If mem_rsp_id differs from the head owner, the response SHALL still be delivered to the head owner and err SHALL be set.
REQ-011 mem_rsp_valid with an empty FIFO SHALL be ignored (no ch_data_ok, no pop) and err SHALL be set.
REQ-012 A full FIFO SHALL block the push even if a pop occurs in the same cycle.
REQ-013 A simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the count unchanged.
REQ-014 Read and write pointers SHALL wrap modulo DEPTH; outstanding SHALL equal the FIFO count and SHALL never exceed DEPTH.
REQ-015 err SHALL clear only on reset.

Reset
REQ-016 The following SHALL be asynchronously cleared when resetn=0:
- rr_ptr=0;
- FIFO pointers and count = 0;
- err=0.
REQ-017 During reset, all outputs SHALL be 0 except data fields derived from inputs.
REQ-018 Reset mid-transaction SHALL discard all outstanding owners; responses arriving after reset SHALL follow REQ-011.

Structure
REQ-019 DEPTH/NUM_CH defaults and the size encoding constants SHALL live in the shared header alongside the existing bus-width macros.
REQ-020 The owner FIFO SHALL be a sub-module, sync_fifo_ptr (parameters WIDTH, DEPTH; outputs full, empty, count).

Verification
REQ-021 ch_req=2'b11, mem_req_ready=1 for 4 cycles -> grants 0,1,0,1; each ch_addr_ok is one-hot.
REQ-022 DEPTH=4, only ch0 requesting, mem_req_ready=1, no responses -> exactly 4 addr_ok, then mem_req_valid=0 and outstanding=4; with ch_req still high:
- one mem_rsp_valid -> ch_data_ok[0]=1 that cycle;
- next cycle, a 5th request is accepted.
REQ-023 Push ch1 then ch0; responses return with rdata 0x11111111 then 0x22222222 -> ch_data_ok=2'b10 with ch_rdata=0x11111111, then 2'b01 with ch_rdata=0x22222222.
REQ-024 mem_rsp_valid=1 while outstanding=0 -> no ch_data_ok, err=1 and err stays high until resetn=0.
REQ-025 mem_req_ready=0 for 3 cycles with ch_req=2'b11 -> grant holds on the same channel; rr_ptr unchanged until ready=1.
REQ-026 resetn pulsed low with outstanding=3 -> outstanding=0, rr_ptr=0 and err=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/sram_req_arbiter_pkg.sv
// Shared definitions for the SRAM request arbiter: bus widths, defaults and
// the access-size encoding.
package sram_req_arbiter_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_STRB_W = 4;

  localparam int DEF_NUM_CH = 2;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_ID_W   = 3;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

endpackage

// File: rtl/sram_req_arbiter_fifo.sv
// Owner FIFO: remembers which channel issued each outstanding request so the
// in-order responses can be routed back. A full FIFO refuses a push even when
// a pop happens in the same cycle.
module sync_fifo_ptr #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is only meaningful behind the pointers, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Round-robin arbiter funnelling several SRAM-like request channels onto one
// downstream port. Accepts are zero-cycle; responses return in order and are
// steered to the channel at the head of the owner FIFO.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ID_W   = DEF_ID_W
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_CH-1:0]            ch_req,
  input  logic [NUM_CH-1:0]            ch_wr,
  input  logic [2*NUM_CH-1:0]          ch_size,
  input  logic [BUS_STRB_W*NUM_CH-1:0] ch_wstrb,
  input  logic [BUS_ADDR_W*NUM_CH-1:0] ch_addr,
  input  logic [BUS_DATA_W*NUM_CH-1:0] ch_wdata,
  output logic [NUM_CH-1:0]            ch_addr_ok,
  output logic [NUM_CH-1:0]            ch_data_ok,
  output logic [BUS_DATA_W-1:0]        ch_rdata,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic                         mem_req_wr,
  output logic [1:0]                   mem_req_size,
  output logic [BUS_STRB_W-1:0]        mem_req_wstrb,
  output logic [BUS_ADDR_W-1:0]        mem_req_addr,
  output logic [BUS_DATA_W-1:0]        mem_req_wdata,
  output logic [ID_W-1:0]              mem_req_id,
  input  logic                         mem_rsp_valid,
  input  logic [ID_W-1:0]              mem_rsp_id,
  input  logic [BUS_DATA_W-1:0]        mem_rsp_rdata,
  output logic [$clog2(DEPTH):0]       outstanding,
  output logic                         err
);

  logic [ID_W-1:0]          r_rr_ptr;
  logic                     r_hold;
  logic [ID_W-1:0]          r_hold_ch;
  logic                     r_err;

  logic [NUM_CH-1:0]        w_elig;
  logic [ID_W-1:0]          w_grant;
  logic                     w_found;
  logic                     w_accept;
  logic                     w_rsp_take;
  logic                     w_fifo_full;
  logic                     w_fifo_empty;
  logic [ID_W-1:0]          w_head;
  logic [$clog2(DEPTH):0]   w_count;

  // Gating with resetn keeps every control output low while reset is held.
  assign w_elig        = resetn ? (ch_req & {NUM_CH{~w_fifo_full}}) : '0;
  assign mem_req_valid = |w_elig;
  assign mem_req_id    = w_grant;
  assign w_accept      = mem_req_valid && mem_req_ready;
  assign w_rsp_take    = mem_rsp_valid && !w_fifo_empty;
  assign ch_rdata      = mem_rsp_rdata;
  assign outstanding   = w_count;
  assign err           = r_err;

  // Grant selection: a stalled grant is held while its channel still asks;
  // otherwise search from rr_ptr, wrapping modulo NUM_CH.
  always_comb begin
    w_grant = r_rr_ptr;
    w_found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!w_found && r_hold && w_elig[k] && (r_hold_ch == ID_W'(k))) begin
        w_grant = ID_W'(k);
        w_found = 1'b1;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (!w_found && w_elig[k] && (k == (int'(r_rr_ptr) + i) % NUM_CH)) begin
          w_grant = ID_W'(k);
          w_found = 1'b1;
        end
      end
    end
  end

  // Request mux and per-channel handshake strobes.
  always_comb begin
    mem_req_wr    = 1'b0;
    mem_req_size  = '0;
    mem_req_wstrb = '0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    ch_addr_ok    = '0;
    ch_data_ok    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_grant == ID_W'(k)) begin
        mem_req_wr    = ch_wr[k];
        mem_req_size  = ch_size[2*k +: 2];
        mem_req_wstrb = ch_wstrb[BUS_STRB_W*k +: BUS_STRB_W];
        mem_req_addr  = ch_addr[BUS_ADDR_W*k +: BUS_ADDR_W];
        mem_req_wdata = ch_wdata[BUS_DATA_W*k +: BUS_DATA_W];
      end
      ch_addr_ok[k] = w_accept && (w_grant == ID_W'(k));
      ch_data_ok[k] = w_rsp_take && (w_head == ID_W'(k));
    end
  end

  // Round-robin pointer advance, stall-hold tracking and sticky error flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rr_ptr  <= '0;
      r_hold    <= 1'b0;
      r_hold_ch <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_grant == ID_W'(NUM_CH - 1)) r_rr_ptr <= '0;
        else                               r_rr_ptr <= w_grant + 1'b1;
      end
      r_hold    <= mem_req_valid && !mem_req_ready;
      r_hold_ch <= w_grant;
      if (mem_rsp_valid && (w_fifo_empty || (mem_rsp_id != w_head))) r_err <= 1'b1;
    end
  end

  sync_fifo_ptr #(
    .WIDTH (ID_W),
    .DEPTH (DEPTH)
  ) u_owner_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (w_accept),
    .din    (w_grant),
    .pop    (w_rsp_take),
    .dout   (w_head),
    .full   (w_fifo_full),
    .empty  (w_fifo_empty),
    .count  (w_count)
  );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter with NUM_CH=2, DEPTH=4.
module tb_sram_req_arbiter;
  import sram_req_arbiter_pkg::*;

  localparam int NUM_CH = 2;
  localparam int DEPTH  = 4;
  localparam int ID_W   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 resetn;
  logic [NUM_CH-1:0]    ch_req, ch_wr, ch_addr_ok, ch_data_ok;
  logic [2*NUM_CH-1:0]  ch_size;
  logic [4*NUM_CH-1:0]  ch_wstrb;
  logic [32*NUM_CH-1:0] ch_addr, ch_wdata;
  logic [31:0]          ch_rdata;
  logic                 mem_req_valid, mem_req_ready, mem_req_wr;
  logic [1:0]           mem_req_size;
  logic [3:0]           mem_req_wstrb;
  logic [31:0]          mem_req_addr, mem_req_wdata;
  logic [ID_W-1:0]      mem_req_id;
  logic                 mem_rsp_valid;
  logic [ID_W-1:0]      mem_rsp_id;
  logic [31:0]          mem_rsp_rdata;
  logic [2:0]           outstanding;
  logic                 err;

  int n_tests = 0;
  int n_fail  = 0;

  sram_req_arbiter #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk(clk), .resetn(resetn),
    .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size), .ch_wstrb(ch_wstrb),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok), .ch_rdata(ch_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wr(mem_req_wr), .mem_req_size(mem_req_size), .mem_req_wstrb(mem_req_wstrb),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_id(mem_req_id),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_id(mem_rsp_id), .mem_rsp_rdata(mem_rsp_rdata),
    .outstanding(outstanding), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn        = 1'b0;
    ch_req        = 2'b11;
    ch_wr         = 2'b10;
    ch_size       = {SIZE_HALF, SIZE_WORD};
    ch_wstrb      = {4'h3, 4'hF};
    ch_addr       = {32'h2000_0004, 32'h1000_0000};
    ch_wdata      = {32'hBBBB_0001, 32'hAAAA_0000};
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_id    = '0;
    mem_rsp_rdata = 32'hDEAD_BEEF;

    // Reset state with requests and responses already asserted.
    #1;
    chk("rst_valid", mem_req_valid, 0);
    chk("rst_addr_ok", ch_addr_ok, 0);
    chk("rst_data_ok", ch_data_ok, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_id", mem_req_id, 0);
    tick(); tick();
    chk("rst_err_held", err, 0);
    chk("rst_rdata_passthru", ch_rdata, 32'hDEAD_BEEF);

    resetn = 1'b1;
    mem_rsp_valid = 1'b0;
    ch_req = 2'b00;
    tick();

    // Alternating grants with both channels requesting.
    ch_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_valid", mem_req_valid, 1);
      chk("rr_id", mem_req_id, i % 2);
      chk("rr_addr_ok", ch_addr_ok, (i % 2) ? 2'b10 : 2'b01);
      chk("rr_addr", mem_req_addr, (i % 2) ? 32'h2000_0004 : 32'h1000_0000);
      chk("rr_wdata", mem_req_wdata, (i % 2) ? 32'hBBBB_0001 : 32'hAAAA_0000);
      chk("rr_wr", mem_req_wr, i % 2);
      chk("rr_size", mem_req_size, (i % 2) ? 2'd1 : 2'd2);
      chk("rr_wstrb", mem_req_wstrb, (i % 2) ? 4'h3 : 4'hF);
      tick();
    end
    #1;
    chk("full_valid", mem_req_valid, 0);
    chk("full_outstanding", outstanding, 4);

    // Drain in order 0,1,0,1.
    ch_req = 2'b00;
    mem_rsp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_rsp_id    = ID_W'(i % 2);
      mem_rsp_rdata = 32'h0000_00A0 + i;
      #1;
      chk("drain_data_ok", ch_data_ok, (i % 2) ? 2'b10 : 2'b01);
      chk("drain_rdata", ch_rdata, 32'h0000_00A0 + i);
      tick();
    end
    mem_rsp_valid = 1'b0;
    #1;
    chk("drain_outstanding", outstanding, 0);
    chk("drain_err", err, 0);

    // Push ch1 then ch0, responses come back to ch1 then ch0.
    ch_req = 2'b10;
    #1; chk("ord_ok1", ch_addr_ok, 2'b10);
    tick();
    ch_req = 2'b01;
    #1; chk("ord_ok0", ch_addr_ok, 2'b01);
    tick();
    ch_req = 2'b00;
    mem_rsp_valid = 1'b1; mem_rsp_id = 3'd1; mem_rsp_rdata = 32'h1111_1111;
    #1;
    chk("ord_rsp1_ok", ch_data_ok, 2'b10);
    chk("ord_rsp1_data", ch_rdata, 32'h1111_1111);
    tick();
    mem_rsp_id = 3'd0; mem_rsp_rdata = 32'h2222_2222;
    #1;
    chk("ord_rsp0_ok", ch_data_ok, 2'b01);
    chk("ord_rsp0_data", ch_rdata, 32'h2222_2222);
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    chk("ord_outstanding", outstanding, 0);
    chk("ord_err", err, 0);

    // Stall: rr_ptr is 1, grant must sit on ch1 while ready is low.
    ch_req = 2'b11;
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_valid", mem_req_valid, 1);
      chk("stall_id", mem_req_id, 1);
      chk("stall_addr_ok", ch_addr_ok, 0);
      chk("stall_rr", dut.r_rr_ptr, 1);
      tick();
    end
    mem_req_ready = 1'b1;
    #1; chk("stall_release", ch_addr_ok, 2'b10);
    tick();
    chk("stall_rr_adv", dut.r_rr_ptr, 0);
    #1; chk("stall_next", ch_addr_ok, 2'b01);
    tick();
    ch_req = 2'b01;
    #1; chk("third_push", ch_addr_ok, 2'b01);
    tick();
    chk("pre_rst_outstanding", outstanding, 3);

    // Asynchronous reset mid-cycle with three owners in flight.
    ch_req = 2'b11;
    #2;
    resetn = 1'b0;
    #1;
    chk("async_outstanding", outstanding, 0);
    chk("async_rr", dut.r_rr_ptr, 0);
    chk("async_err", err, 0);
    chk("async_valid", mem_req_valid, 0);
    ch_req = 2'b00;
    tick();
    resetn = 1'b1;
    tick();

    // Response to an empty FIFO after reset: ignored, err sticky.
    mem_rsp_valid = 1'b1; mem_rsp_id = 3'd0; mem_rsp_rdata = 32'h5555_5555;
    #1;
    chk("orphan_data_ok", ch_data_ok, 0);
    tick();
    mem_rsp_valid = 1'b0;
    chk("orphan_err", err, 1);
    chk("orphan_outstanding", outstanding, 0);

    // Single requester fills the FIFO, then a pop makes room for a fifth.
    ch_req = 2'b01;
    for (int i = 0; i < 4; i++) begin
      #1; chk("fill_addr_ok", ch_addr_ok, 2'b01);
      tick();
    end
    #1;
    chk("fill_valid", mem_req_valid, 0);
    chk("fill_outstanding", outstanding, 4);
    mem_rsp_valid = 1'b1; mem_rsp_id = 3'd0; mem_rsp_rdata = 32'h0000_0001;
    #1;
    chk("fill_pop_ok", ch_data_ok, 2'b01);
    chk("fill_no_push", ch_addr_ok, 0);
    tick();
    mem_rsp_valid = 1'b0;
    chk("fill_after_pop", outstanding, 3);
    #1; chk("fifth_addr_ok", ch_addr_ok, 2'b01);
    tick();
    chk("fifth_outstanding", outstanding, 4);

    // Pop one, then simultaneous push and pop keeps the count.
    ch_req = 2'b00;
    mem_rsp_valid = 1'b1;
    tick();
    chk("pp_pre", outstanding, 3);
    ch_req = 2'b01;
    #1;
    chk("pp_addr_ok", ch_addr_ok, 2'b01);
    chk("pp_data_ok", ch_data_ok, 2'b01);
    tick();
    chk("pp_count", outstanding, 3);
    ch_req = 2'b00;
    tick(); tick(); tick();
    mem_rsp_valid = 1'b0;
    chk("pp_drained", outstanding, 0);
    chk("err_still_set", err, 1);

    // Reset clears err; then a mismatched id still goes to the head owner.
    resetn = 1'b0;
    #1; chk("err_cleared", err, 0);
    tick();
    resetn = 1'b1;
    tick();
    ch_req = 2'b10;
    tick();
    ch_req = 2'b00;
    mem_rsp_valid = 1'b1; mem_rsp_id = 3'd0; mem_rsp_rdata = 32'h3333_3333;
    #1;
    chk("mis_data_ok", ch_data_ok, 2'b10);
    chk("mis_rdata", ch_rdata, 32'h3333_3333);
    tick();
    mem_rsp_valid = 1'b0;
    chk("mis_err", err, 1);
    chk("mis_outstanding", outstanding, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
